hilo_muldiv: RTL and testbench

Multi-cycle multiply/divide responder with HI/LO registers, sitting in the E stage of the five-stage pipeline. The E stage issues a command with a single-cycle `start`, and the unit reports `busy` while an operation is in flight. The stall controller treats `start | busy` as a structural hazard for any following HI/LO instruction. Results are read back combinationally through `out` for MFHI/MFLO.

---
 rtl/hilo_muldiv.sv | 85 ++++++++
 tb/tb_hilo_muldiv.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle MULT/DIV unit with HI/LO registers and MFHI/MFLO/MTHI/MTLO access.
// Define HILO_MADD_EN to enable MADD/MADDU accumulate into {HI,LO}.
module hilo_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mudeop,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic [31:0] out
);
  localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
`ifdef HILO_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] hi, lo, a_q, b_q;
  logic sgn_q, div_q, acc_q;
  logic is_mul, is_div, is_madd, launch;
  logic [63:0] a_ext, b_ext, acc, res;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  // Datapath is combinational off the latched operands; it has the whole busy window to settle.
  always_comb begin
    is_mul = mudeop[3:1] == 3'b000;
    is_div = mudeop[3:1] == 3'b001;
    is_madd = MADD_EN && mudeop[3:1] == 3'b100;
    launch = start && state == IDLE && (is_mul || is_div || is_madd);
    a_ext = {{32{sgn_q & a_q[31]}}, a_q};
    b_ext = {{32{sgn_q & b_q[31]}}, b_q};
    acc = acc_q ? {hi, lo} : 64'd0;
    a_mag = sgn_q && a_q[31] ? -a_q : a_q;
    b_mag = sgn_q && b_q[31] ? -b_q : b_q;
    q_mag = b_mag == 32'd0 ? 32'd0 : a_mag / b_mag;
    r_mag = b_mag == 32'd0 ? 32'd0 : a_mag % b_mag;
    quot = sgn_q && (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
    rem = sgn_q && a_q[31] ? -r_mag : r_mag;
    res = div_q ? {rem, quot} : acc + a_ext * b_ext;
  end
  assign out = mudeop == 4'b0100 ? hi : mudeop == 4'b0101 ? lo : 32'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      cnt <= '0;
      hi <= 32'd0;
      lo <= 32'd0;
      a_q <= 32'd0;
      b_q <= 32'd0;
      sgn_q <= 1'b0;
      div_q <= 1'b0;
      acc_q <= 1'b0;
    end else if (state == IDLE) begin
      if (launch) begin
        a_q <= src1;
        b_q <= src2;
        sgn_q <= ~mudeop[0];
        div_q <= is_div;
        acc_q <= is_madd;
        cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        busy <= 1'b1;
        state <= RUN;
      end else if (start && mudeop == 4'b0110) begin
        hi <= src1;
      end else if (start && mudeop == 4'b0111) begin
        lo <= src1;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= IDLE;
        busy <= 1'b0;
        if (!(div_q && b_q == 32'd0)) {hi, lo} <= res;
      end
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: vector table, hand-written corner sequences and random ops against an arithmetic model.
module tb_hilo_muldiv;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef HILO_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, busy;
  logic [3:0] mudeop = 4'hC;
  logic [31:0] src1 = 32'd0, src2 = 32'd0, out;
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;
  int errors = 0, checks = 0;

  hilo_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mudeop(mudeop),
    .src1(src1), .src2(src2), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [31:0] a, b;
    int cyc;
    logic [31:0] hi, lo;
  } vec_t;
  vec_t vecs[12];
  logic [3:0] ops[9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    start = 1'b1; mudeop = op; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0; mudeop = 4'hC;
    n = 0;
    while (busy && n < 100) begin
      src1 = $urandom; src2 = $urandom;
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Reads LO every busy cycle (must hold the old value) and injects a stray start at busy cycle 2.
  task automatic run_pulse(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] pop, input logic [31:0] pa, input logic [31:0] old_lo,
                           output int n);
    start = 1'b1; mudeop = op; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0; mudeop = 4'h5;
    n = 0;
    while (busy && n < 100) begin
      #1 check("mflo during run", out, old_lo);
      if (n == 1) begin start = 1'b1; mudeop = pop; src1 = pa; src2 = pa; end
      @(posedge clk); #1;
      start = 1'b0; mudeop = 4'h5;
      n++;
    end
    mudeop = 4'hC;
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    mudeop = 4'h4; #1 check({name, " hi"}, out, eh);
    mudeop = 4'h5; #1 check({name, " lo"}, out, el);
    mudeop = 4'hC; #1;
  endtask

  function automatic int model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p = (op == 4'h0 || op == 4'h8) ? 64'(sa * sb) : ua * ub;
    if (op <= 4'h1 || (MADD && op inside {4'h8, 4'h9})) begin
      if (op[3]) p = p + {hi_m, lo_m};
      {hi_m, lo_m} = p;
      return MC;
    end
    if (op == 4'h2) begin
      if (b != 0) begin hi_m = 32'(sa % sb); lo_m = 32'(sa / sb); end
      return DC;
    end
    if (op == 4'h3) begin
      if (b != 0) begin hi_m = a % b; lo_m = a / b; end
      return DC;
    end
    if (op == 4'h6) hi_m = a;
    if (op == 4'h7) lo_m = a;
    return 0;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n, n2, e;
    logic [31:0] a, b;
    logic [3:0] op;
    vecs[0]  = '{4'h0, 32'hFFFFFFFD, 32'h00000007, MC, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{4'h1, 32'hFFFFFFFF, 32'h00000002, MC, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{4'h2, 32'hFFFFFFF9, 32'h00000002, DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{4'h3, 32'h00000007, 32'h00000000, DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{4'h6, 32'h12345678, 32'h00000000, 0,  32'h12345678, 32'hFFFFFFFD};
    vecs[5]  = '{4'h7, 32'hCAFEF00D, 32'h00000000, 0,  32'h12345678, 32'hCAFEF00D};
    vecs[6]  = '{4'hF, 32'h00000001, 32'h00000002, 0,  32'h12345678, 32'hCAFEF00D};
    vecs[7]  = '{4'h4, 32'h00000005, 32'h00000005, 0,  32'h12345678, 32'hCAFEF00D};
    vecs[8]  = '{4'h2, 32'h00000007, 32'hFFFFFFFE, DC, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{4'h3, 32'h00000064, 32'h00000007, DC, 32'h00000002, 32'h0000000E};
    vecs[10] = '{4'h0, 32'h80000000, 32'h80000000, MC, 32'h40000000, 32'h00000000};
    vecs[11] = '{4'h3, 32'hFFFFFFFF, 32'h0000000A, DC, 32'h00000005, 32'h19999999};

    #2 check("reset busy", {31'd0, busy}, 32'd0);
    mudeop = 4'h4; #1 check("reset hi", out, 32'd0);
    mudeop = 4'h5; #1 check("reset lo", out, 32'd0);
    mudeop = 4'hC;
    #6 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      check($sformatf("vec%0d cycles", i), n, vecs[i].cyc);
      check_hilo($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
    end
    check("out non-mf op", out, 32'd0);

    run_pulse(4'h0, 32'd3, 32'd4, 4'h7, 32'hDEADBEEF, 32'h19999999, n);
    check("mult with stray mtlo cycles", n, MC);
    check_hilo("mult with stray mtlo", 32'd0, 32'd12);
    run_pulse(4'h3, 32'd7, 32'd0, 4'h0, 32'd9, 32'd12, n);
    check("divu0 with stray mult cycles", n, DC);
    check_hilo("divu0 with stray mult", 32'd0, 32'd12);

    run_op(4'h0, 32'd6, 32'd7, n);
    run_op(4'h3, 32'd5, 32'd0, n2);
    check("b2b first cycles", n, MC);
    check("b2b second cycles", n2, DC);
    check_hilo("b2b", 32'd0, 32'd42);

    run_op(4'h6, 32'd0, 32'd0, n);
    run_op(4'h7, 32'hFFFFFFFF, 32'd0, n);
    run_op(4'h9, 32'd1, 32'd1, n);
    check("maddu cycles", n, MADD ? MC : 0);
    check_hilo("maddu", MADD ? 32'd1 : 32'd0, MADD ? 32'd0 : 32'hFFFFFFFF);

    hi_m = MADD ? 32'd1 : 32'd0;
    lo_m = MADD ? 32'd0 : 32'hFFFFFFFF;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 8)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      e = model(op, a, b);
      run_op(op, a, b, n);
      check($sformatf("rand%0d op%0h cycles", i, op), n, e);
      check_hilo($sformatf("rand%0d op%0h", i, op), hi_m, lo_m);
    end

    run_op(4'h6, 32'h11, 32'd0, n);
    start = 1'b1; mudeop = 4'h2; src1 = 32'd100; src2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; mudeop = 4'hC;
    repeat (3) @(posedge clk);
    #1 check("busy before abort", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1 check("abort busy", {31'd0, busy}, 32'd0);
    mudeop = 4'h4; #1 check("abort hi", out, 32'd0);
    mudeop = 4'h5; #1 check("abort lo", out, 32'd0);
    mudeop = 4'hC;
    #1 reset = 1'b1;
    n = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (busy) n++;
    end
    check("post abort busy cycles", n, 0);
    check_hilo("post abort", 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
